// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ARM-subset instruction decode stage.
// Holds ALU commands, data-processing opcodes, instruction modes and condition codes.
package id_stage_pkg;

  localparam int unsigned NumRegs = 15;

  // ALU commands sent to EX
  localparam logic [3:0] ExNop = 4'b0000;
  localparam logic [3:0] ExMov = 4'b0001;
  localparam logic [3:0] ExAdd = 4'b0010;
  localparam logic [3:0] ExAdc = 4'b0011;
  localparam logic [3:0] ExSub = 4'b0100;
  localparam logic [3:0] ExSbc = 4'b0101;
  localparam logic [3:0] ExAnd = 4'b0110;
  localparam logic [3:0] ExOrr = 4'b0111;
  localparam logic [3:0] ExEor = 4'b1000;
  localparam logic [3:0] ExMvn = 4'b1001;

  // Data-processing opcodes
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;
  localparam logic [3:0] OpMem = 4'b0100;

  typedef enum logic [1:0] {
    ModeAlu    = 2'b00,
    ModeMem    = 2'b01,
    ModeBranch = 2'b10,
    ModeNone   = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CondEq = 4'b0000, CondNe = 4'b0001, CondCs = 4'b0010, CondCc = 4'b0011,
    CondMi = 4'b0100, CondPl = 4'b0101, CondVs = 4'b0110, CondVc = 4'b0111,
    CondHi = 4'b1000, CondLs = 4'b1001, CondGe = 4'b1010, CondLt = 4'b1011,
    CondGt = 4'b1100, CondLe = 4'b1101, CondAl = 4'b1110, CondNv = 4'b1111
  } cond_e;

  // nzcv is {N,Z,C,V}; CondNv never executes
  function automatic logic cond_pass(cond_e cond, logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    unique case (cond)
      CondEq:  pass = z;
      CondNe:  pass = ~z;
      CondCs:  pass = c;
      CondCc:  pass = ~c;
      CondMi:  pass = n;
      CondPl:  pass = ~n;
      CondVs:  pass = v;
      CondVc:  pass = ~v;
      CondHi:  pass = c & ~z;
      CondLs:  pass = ~c | z;
      CondGe:  pass = (n == v);
      CondLt:  pass = (n != v);
      CondGt:  pass = ~z & (n == v);
      CondLe:  pass = z | (n != v);
      CondAl:  pass = 1'b1;
      CondNv:  pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its surroundings (IF, EX, WB, hazard unit).
// The slave modport is the decode stage; the master modport drives it.
interface id_stage_if;
  logic [31:0] Instruction;
  logic [31:0] PC_in;
  logic [3:0]  Status_Register;
  logic        Hazard;
  logic        WB_WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;

  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN;
  logic        Imm;
  logic        B;
  logic        S;
  logic [3:0]  EX_CMD;
  logic [3:0]  Dest;
  logic [11:0] shifter_operand;
  logic [23:0] signed_immediate;
  logic [31:0] PC;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        Two_src;

  modport master (
    output Instruction, PC_in, Status_Register, Hazard, WB_WB_EN, WB_Dest, WB_Value,
    input  MEM_R_EN, MEM_W_EN, WB_EN, Imm, B, S, EX_CMD, Dest, shifter_operand,
    input  signed_immediate, PC, Val_Rn, Val_Rm, src1, src2, Two_src
  );

  modport slave (
    input  Instruction, PC_in, Status_Register, Hazard, WB_WB_EN, WB_Dest, WB_Value,
    output MEM_R_EN, MEM_W_EN, WB_EN, Imm, B, S, EX_CMD, Dest, shifter_operand,
    output signed_immediate, PC, Val_Rn, Val_Rm, src1, src2, Two_src
  );
endinterface

// File: rtl/id_stage_register_file.sv
// 15 x 32 register file (R0..R14), written on the falling clock edge so that
// decode sees a same-cycle writeback. Address 15 reads as zero and is never written.
module register_file
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  raddr1_i,
  input  logic [3:0]  raddr2_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [NumRegs];
  logic [31:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 4'hF)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Reset loads Ri = i and wins over any write in flight
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 32'(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1_o = (raddr1_i == 4'hF) ? 32'h0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 4'hF) ? 32'h0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, condition check and register read,
// all combinational; only the register file holds state.
module id_stage
  import id_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  id_stage_if.slave id_bus
);

  logic [31:0] instr;
  mode_e       mode;
  cond_e       cond;
  logic [3:0]  opcode;
  logic        s_field;
  logic        i_field;
  logic [3:0]  rn, rd, rm;

  assign instr   = id_bus.Instruction;
  assign cond    = cond_e'(instr[31:28]);
  assign mode    = mode_e'(instr[27:26]);
  assign i_field = instr[25];
  assign opcode  = instr[24:21];
  assign s_field = instr[20];
  assign rn      = instr[19:16];
  assign rd      = instr[15:12];
  assign rm      = instr[3:0];

  logic       mem_r, mem_w, wb, br, s_bit;
  logic [3:0] ex_cmd;

  always_comb begin
    mem_r  = 1'b0;
    mem_w  = 1'b0;
    wb     = 1'b0;
    br     = 1'b0;
    s_bit  = 1'b0;
    ex_cmd = ExNop;
    unique case (mode)
      ModeAlu: begin
        s_bit = s_field;
        wb    = 1'b1;
        case (opcode)
          OpMov:   ex_cmd = ExMov;
          OpMvn:   ex_cmd = ExMvn;
          OpAdd:   ex_cmd = ExAdd;
          OpAdc:   ex_cmd = ExAdc;
          OpSub:   ex_cmd = ExSub;
          OpSbc:   ex_cmd = ExSbc;
          OpAnd:   ex_cmd = ExAnd;
          OpOrr:   ex_cmd = ExOrr;
          OpEor:   ex_cmd = ExEor;
          OpCmp: begin
            ex_cmd = ExSub;
            wb     = 1'b0;
          end
          OpTst: begin
            ex_cmd = ExAnd;
            wb     = 1'b0;
          end
          default: wb = 1'b0;
        endcase
      end
      ModeMem: begin
        s_bit = s_field;
        if (opcode == OpMem) begin
          ex_cmd = ExAdd;
          mem_r  = s_field;
          wb     = s_field;
          mem_w  = ~s_field;
        end
      end
      ModeBranch: br = 1'b1;
      default: ;
    endcase
  end

  // Squash side-effecting controls on a failed condition or a stall
  logic squash;
  assign squash = id_bus.Hazard | ~cond_pass(cond, id_bus.Status_Register);

  assign id_bus.MEM_R_EN = mem_r & ~squash;
  assign id_bus.MEM_W_EN = mem_w & ~squash;
  assign id_bus.WB_EN    = wb & ~squash;
  assign id_bus.B        = br & ~squash;
  assign id_bus.S        = s_bit & ~squash;
  assign id_bus.Imm      = i_field;
  assign id_bus.EX_CMD   = ex_cmd;

  assign id_bus.Dest             = rd;
  assign id_bus.shifter_operand  = instr[11:0];
  assign id_bus.signed_immediate = instr[23:0];
  assign id_bus.PC               = id_bus.PC_in;

  // STR reads Rd as the store data, so its address rides on the second port
  logic [3:0] src2;
  assign src2           = mem_w ? rd : rm;
  assign id_bus.src1    = rn;
  assign id_bus.src2    = src2;
  assign id_bus.Two_src = ~i_field | mem_w;

  register_file u_register_file (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rn),
    .raddr2_i (src2),
    .we_i     (id_bus.WB_WB_EN),
    .waddr_i  (id_bus.WB_Dest),
    .wdata_i  (id_bus.WB_Value),
    .rdata1_o (id_bus.Val_Rn),
    .rdata2_o (id_bus.Val_Rm)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations are queued when stimulus is applied
// and checked with immediate assertions once the decode outputs settle.
module tb_id_stage;

  logic clk;
  logic rst;

  id_stage_if bus_if ();

  id_stage dut (
    .clk    (clk),
    .rst    (rst),
    .id_bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SelValRn  = 0;
  localparam int SelValRm  = 1;
  localparam int SelExCmd  = 2;
  localparam int SelWbEn   = 3;
  localparam int SelDest   = 4;
  localparam int SelTwoSrc = 5;
  localparam int SelMemR   = 6;
  localparam int SelMemW   = 7;
  localparam int SelB      = 8;
  localparam int SelS      = 9;
  localparam int SelImm    = 10;
  localparam int SelSimm   = 11;
  localparam int SelSrc2   = 12;
  localparam int SelPc     = 13;
  localparam int SelShift  = 14;
  localparam int SelSrc1   = 15;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      SelValRn:  return bus_if.Val_Rn;
      SelValRm:  return bus_if.Val_Rm;
      SelExCmd:  return 32'(bus_if.EX_CMD);
      SelWbEn:   return 32'(bus_if.WB_EN);
      SelDest:   return 32'(bus_if.Dest);
      SelTwoSrc: return 32'(bus_if.Two_src);
      SelMemR:   return 32'(bus_if.MEM_R_EN);
      SelMemW:   return 32'(bus_if.MEM_W_EN);
      SelB:      return 32'(bus_if.B);
      SelS:      return 32'(bus_if.S);
      SelImm:    return 32'(bus_if.Imm);
      SelSimm:   return 32'(bus_if.signed_immediate);
      SelSrc2:   return 32'(bus_if.src2);
      SelPc:     return bus_if.PC;
      SelShift:  return 32'(bus_if.shifter_operand);
      SelSrc1:   return 32'(bus_if.src1);
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Independent reference for the ARM condition field, flags given as {N,Z,C,V}
  function automatic logic cond_model(logic [3:0] c, logic [3:0] st);
    logic n, z, cy, v;
    n  = st[3];
    z  = st[2];
    cy = st[1];
    v  = st[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = obs(e.sel);
      checks++;
      assert (got === e.exp)
      else begin
        failures++;
        $error("FAIL %s got=%h exp=%h", e.tag, got, e.exp);
      end
    end
  endtask

  // Apply one decode cycle; outputs are sampled after the falling-edge write
  task automatic cycle(input logic [31:0] instr, input logic [3:0] st, input logic hz);
    @(posedge clk);
    #1;
    bus_if.Instruction     = instr;
    bus_if.Status_Register = st;
    bus_if.Hazard          = hz;
    @(negedge clk);
    #1;
    drain();
  endtask

  task automatic wb_set(input logic en, input logic [3:0] dst, input logic [31:0] val);
    bus_if.WB_WB_EN = en;
    bus_if.WB_Dest  = dst;
    bus_if.WB_Value = val;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.Instruction     = 32'h0;
    bus_if.PC_in           = 32'h0;
    bus_if.Status_Register = 4'h0;
    bus_if.Hazard          = 1'b0;
    wb_set(1'b0, 4'h0, 32'h0);

    // Reset contents visible immediately through the combinational read path
    #2;
    bus_if.Instruction = 32'hE08E100D;
    #1;
    expect_val("rst_r14", SelValRn, 32'd14);
    expect_val("rst_r13", SelValRm, 32'd13);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b0;

    // ADD R1,R2,R3
    bus_if.PC_in = 32'h0000_0104;
    expect_val("add_rn", SelValRn, 32'd2);
    expect_val("add_rm", SelValRm, 32'd3);
    expect_val("add_cmd", SelExCmd, 32'h2);
    expect_val("add_wb", SelWbEn, 32'd1);
    expect_val("add_dest", SelDest, 32'd1);
    expect_val("add_two", SelTwoSrc, 32'd1);
    expect_val("add_memw", SelMemW, 32'd0);
    expect_val("add_pc", SelPc, 32'h0000_0104);
    expect_val("add_src1", SelSrc1, 32'd2);
    cycle(32'hE0821003, 4'h0, 1'b0);

    // Same-cycle writeback R5 then MOV R0,R5
    wb_set(1'b1, 4'd5, 32'hDEADBEEF);
    expect_val("mov_rm", SelValRm, 32'hDEADBEEF);
    expect_val("mov_cmd", SelExCmd, 32'h1);
    expect_val("mov_wb", SelWbEn, 32'd1);
    cycle(32'hE1A00005, 4'h0, 1'b0);
    wb_set(1'b0, 4'd0, 32'h0);

    // BNE with Z set does not branch; with Z clear it does
    expect_val("bne_z_b", SelB, 32'd0);
    cycle(32'h1A000004, 4'b0100, 1'b0);
    expect_val("bne_b", SelB, 32'd1);
    expect_val("bne_simm", SelSimm, 32'h000004);
    expect_val("bne_cmd", SelExCmd, 32'h0);
    expect_val("bne_wb", SelWbEn, 32'd0);
    expect_val("bne_s", SelS, 32'd0);
    cycle(32'h1A000004, 4'b0000, 1'b0);

    // Memory ops need opcode field 0100, so the P bit is clear in these encodings
    expect_val("str_memw", SelMemW, 32'd1);
    expect_val("str_src2", SelSrc2, 32'd1);
    expect_val("str_two", SelTwoSrc, 32'd1);
    expect_val("str_rm", SelValRm, 32'd1);
    expect_val("str_wb", SelWbEn, 32'd0);
    expect_val("str_cmd", SelExCmd, 32'h2);
    cycle(32'hE4821000, 4'h0, 1'b0);
    expect_val("ldr_memr", SelMemR, 32'd1);
    expect_val("ldr_wb", SelWbEn, 32'd1);
    expect_val("ldr_s", SelS, 32'd1);
    expect_val("ldr_src2", SelSrc2, 32'd0);
    expect_val("ldr_memw", SelMemW, 32'd0);
    cycle(32'hE4921000, 4'h0, 1'b0);

    // Hazard squashes side effects but keeps the ALU command
    expect_val("hz_wb", SelWbEn, 32'd0);
    expect_val("hz_memr", SelMemR, 32'd0);
    expect_val("hz_memw", SelMemW, 32'd0);
    expect_val("hz_cmd", SelExCmd, 32'h2);
    expect_val("hz_rn", SelValRn, 32'd2);
    cycle(32'hE0821003, 4'h0, 1'b1);
    expect_val("hz_str_memw", SelMemW, 32'd0);
    cycle(32'hE4821000, 4'h0, 1'b1);

    expect_val("cmp_wb", SelWbEn, 32'd0);
    expect_val("cmp_s", SelS, 32'd1);
    expect_val("cmp_cmd", SelExCmd, 32'h4);
    cycle(32'hE1520003, 4'h0, 1'b0);

    // Unlisted opcode, mode 11, and immediate form
    expect_val("rsb_wb", SelWbEn, 32'd0);
    expect_val("rsb_cmd", SelExCmd, 32'h0);
    cycle(32'hE0621003, 4'h0, 1'b0);
    expect_val("m11_wb", SelWbEn, 32'd0);
    expect_val("m11_b", SelB, 32'd0);
    expect_val("m11_cmd", SelExCmd, 32'h0);
    cycle(32'hEC000000, 4'h0, 1'b0);
    expect_val("imm_imm", SelImm, 32'd1);
    expect_val("imm_two", SelTwoSrc, 32'd0);
    expect_val("imm_shift", SelShift, 32'h005);
    cycle(32'hE2821005, 4'h0, 1'b0);

    // Every condition code against every flag combination
    for (int c = 0; c < 16; c++) begin
      for (int st = 0; st < 16; st++) begin
        expect_val($sformatf("cond_%0h_st_%0h", c, st), SelWbEn,
                   32'(cond_model(4'(c), 4'(st))));
        cycle({4'(c), 28'h0821003}, 4'(st), 1'b0);
      end
    end

    // R15 writes are dropped and R15 reads as zero
    wb_set(1'b1, 4'hF, 32'h5555_5555);
    expect_val("r15_rn", SelValRn, 32'h0);
    expect_val("r14_rm", SelValRm, 32'd14);
    cycle(32'hE08F100E, 4'h0, 1'b0);
    wb_set(1'b0, 4'd0, 32'h0);

    // R4 write works, then reset mid-cycle discards a pending write
    wb_set(1'b1, 4'd4, 32'h0000_0011);
    expect_val("r4_wr", SelValRn, 32'h11);
    cycle(32'hE0841005, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    wb_set(1'b1, 4'd4, 32'hCAFE_0000);
    #2;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    wb_set(1'b0, 4'd0, 32'h0);
    expect_val("rst_r4", SelValRn, 32'd4);
    expect_val("rst_r5", SelValRm, 32'd5);
    cycle(32'hE0841005, 4'h0, 1'b0);

    // First write after reset release lands on the next falling edge
    wb_set(1'b1, 4'd4, 32'h0000_0077);
    expect_val("post_rst_wr", SelValRn, 32'h77);
    cycle(32'hE0841005, 4'h0, 1'b0);
    wb_set(1'b0, 4'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
